// File: rtl/pipe_stage_reg.sv
`default_nettype none
// pipe_stage_reg: valid/ready pipeline latch with flush, bubble insertion and a saturating stall counter.
// Define PIPE_SKID_EN to add a one-entry skid buffer so that in_ready comes straight from a flop.
module pipe_stage_reg #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_free;
  logic              accept;

  assign m_free = !m_valid_q || out_ready;

`ifdef PIPE_SKID_EN
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  assign in_ready = !s_valid_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      // The skid entry is older than anything on the input, so it refills M first.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
        m_ctrl_d  = '0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_data_d  = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end
`else
  assign in_ready = m_free;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end else if (accept) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = in_ctrl;
      m_data_d  = in_data;
    end else if (m_free) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (m_valid_q && !out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q;
  assign out_data  = m_data_q;
  assign stall_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg (CNT_W=4 to reach saturation quickly).
module tb_pipe_stage_reg;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam int NW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          cnt_clr;
  logic [NW-1:0] stall_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .cnt_clr   (cnt_clr),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    flush = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (2) step();
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== 25'h0) $display("FAIL reset_out: got %h want %h", {out_valid, out_ctrl, out_data}, 25'h0);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 4'd0) $display("FAIL reset_cnt: got %0d want 0", stall_cnt);
    else pass_cnt++;
    rst_n = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  task automatic test_stream();
    in_valid = 1'b1; in_ctrl = 8'h5A; in_data = 16'h1234; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'h5A, 16'h1234}) $display("FAIL stream_out: got %h want %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'h5A, 16'h1234});
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 4'd0) $display("FAIL stream_cnt: got %0d want 0", stall_cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl} !== 9'h0) $display("FAIL stream_drain: got %h want %h", {out_valid, out_ctrl}, 9'h0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] ec;
    logic [DW-1:0] ed;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ec = 8'hA1 + 8'(i);
      ed = 16'h1000 + 16'(i);
      in_valid = 1'b1; in_ctrl = ec; in_data = ed;
      step();
      total_cnt++;
      if ({out_valid, out_ctrl, out_data} !== {1'b1, ec, ed}) $display("FAIL b2b_out%0d: got %h want %h", i, {out_valid, out_ctrl, out_data}, {1'b1, ec, ed});
      else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl} !== 9'h0) $display("FAIL b2b_drain: got %h want %h", {out_valid, out_ctrl}, 9'h0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hB1; in_data = 16'h2001;
    step();
    in_ctrl = 8'hB2; in_data = 16'h2002;
    #1;
`ifdef PIPE_SKID_EN
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_skid_free: got %b want 1", in_ready);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_skid_full: got %b want 0", in_ready);
    else pass_cnt++;
    step();
    step();
`else
    total_cnt++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready);
    else pass_cnt++;
    repeat (3) step();
`endif
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hB1, 16'h2001}) $display("FAIL bp_hold: got %h want %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'hB1, 16'h2001});
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 4'd3) $display("FAIL bp_cnt: got %0d want 3", stall_cnt);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hB2, 16'h2002}) $display("FAIL bp_second: got %h want %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'hB2, 16'h2002});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl} !== 9'h0) $display("FAIL bp_drain: got %h want %h", {out_valid, out_ctrl}, 9'h0);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 4'd3) $display("FAIL bp_cnt_hold: got %0d want 3", stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hD1; in_data = 16'h4001;
    step();
    total_cnt++;
    if (out_valid !== 1'b1) $display("FAIL flush_load: got %b want 1", out_valid);
    else pass_cnt++;
    flush = 1'b1; in_ctrl = 8'hD2; in_data = 16'h4002;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, out_ctrl, in_ready} !== {1'b0, 8'h00, 1'b1}) $display("FAIL flush_out: got %h want %h", {out_valid, out_ctrl, in_ready}, {1'b0, 8'h00, 1'b1});
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl} !== 9'h0) $display("FAIL flush_discard: got %h want %h", {out_valid, out_ctrl}, 9'h0);
    else pass_cnt++;
  endtask

`ifdef PIPE_SKID_EN
  task automatic test_flush_skid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hC1; in_data = 16'h3001;
    step();
    in_ctrl = 8'hC2; in_data = 16'h3002;
    step();
    in_ctrl = 8'hC3; in_data = 16'h3003; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_ctrl, in_ready} !== {1'b0, 8'h00, 1'b1}) $display("FAIL skid_flush_out: got %h want %h", {out_valid, out_ctrl, in_ready}, {1'b0, 8'h00, 1'b1});
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL skid_flush_discard1: got %b want 0", out_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL skid_flush_discard2: got %b want 0", out_valid);
    else pass_cnt++;
  endtask
`endif

  task automatic test_bubble();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 8'hE1; in_data = 16'h5001;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hE1, 16'h5001}) $display("FAIL bubble_first: got %h want %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'hE1, 16'h5001});
    else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl} !== 9'h0) $display("FAIL bubble_gap: got %h want %h", {out_valid, out_ctrl}, 9'h0);
    else pass_cnt++;
    in_valid = 1'b1; in_ctrl = 8'hE2; in_data = 16'h5002;
    step();
    in_valid = 1'b0;
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hE2, 16'h5002}) $display("FAIL bubble_second: got %h want %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'hE2, 16'h5002});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({out_valid, out_ctrl} !== 9'h0) $display("FAIL bubble_drain: got %h want %h", {out_valid, out_ctrl}, 9'h0);
    else pass_cnt++;
  endtask

  task automatic test_counter();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total_cnt++;
    if (stall_cnt !== 4'd0) $display("FAIL cnt_clear_idle: got %0d want 0", stall_cnt);
    else pass_cnt++;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hF1; in_data = 16'hBEEF;
    step();
    in_valid = 1'b0;
    repeat (20) step();
    total_cnt++;
    if (stall_cnt !== 4'd15) $display("FAIL cnt_saturate: got %0d want 15", stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== {1'b1, 8'hF1, 16'hBEEF}) $display("FAIL cnt_hold: got %h want %h", {out_valid, out_ctrl, out_data}, {1'b1, 8'hF1, 16'hBEEF});
    else pass_cnt++;
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    total_cnt++;
    if (stall_cnt !== 4'd0) $display("FAIL cnt_clr_wins: got %0d want 0", stall_cnt);
    else pass_cnt++;
    step();
    total_cnt++;
    if (stall_cnt !== 4'd1) $display("FAIL cnt_restart: got %0d want 1", stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, out_ctrl, out_data} !== 25'h0) $display("FAIL async_out: got %h want %h", {out_valid, out_ctrl, out_data}, 25'h0);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 4'd0) $display("FAIL async_cnt: got %0d want 0", stall_cnt);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL async_in_ready: got %b want 1", in_ready);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_to_back();
    test_backpressure();
    test_flush();
`ifdef PIPE_SKID_EN
    test_flush_skid();
`endif
    test_bubble();
    test_counter();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
